cam_frame_capture: RTL and testbench



---
 rtl/cam_pkg.sv | 26 ++
 rtl/cam_frame_capture_if.sv | 25 ++
 rtl/cam_rgb2gray.sv | 33 +++
 rtl/cam_frame_capture.sv | 157 +++++++++++++++
 tb/tb_cam_frame_capture.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture stage: FSM encoding,
// RGB565 field positions and the integer luma weights.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_VS_HI = 2'd1,
    ST_WAIT_VS_LO = 2'd2,
    ST_CAPTURE    = 2'd3
  } cap_state_e;

  // RGB565 field positions within a 16-bit pixel
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // y = (2*r + 5*g + 1*b) >> 3 on 8-bit expanded channels
  localparam int LUMA_R     = 2;
  localparam int LUMA_G     = 5;
  localparam int LUMA_B     = 1;
  localparam int LUMA_SHIFT = 3;

endpackage

// File: rtl/cam_frame_capture_if.sv
// Camera byte bus (inputs plus register clock-enable) and the
// scratchpad pixel write port of the capture stage.
interface cam_frame_capture_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [7:0]            cam_dat;
  logic                  cam_href;
  logic                  cam_vsync;
  logic                  cam_dat_en;
  logic                  px_we;
  logic [ADDR_WIDTH-1:0] px_addr;
  logic [15:0]           px_data;

  // capture stage side
  modport master (
    input  cam_dat, cam_href, cam_vsync,
    output cam_dat_en, px_we, px_addr, px_data
  );

  // camera pads / scratchpad side
  modport slave (
    output cam_dat, cam_href, cam_vsync,
    input  cam_dat_en, px_we, px_addr, px_data
  );
endinterface

// File: rtl/cam_rgb2gray.sv
// Combinational RGB565 -> 8-bit luma. Channels are widened to 8 bits by
// replicating their MSBs so full-scale inputs map to 255.
module cam_rgb2gray
  import cam_pkg::*;
(
  input  logic [15:0] pix,
  output logic [7:0]  y
);

  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [10:0] sum;

  assign r5 = pix[R_MSB:R_LSB];
  assign g6 = pix[G_MSB:G_LSB];
  assign b5 = pix[B_MSB:B_LSB];

  assign r8 = {r5, r5[4:2]};
  assign g8 = {g6, g6[5:4]};
  assign b8 = {b5, b5[4:2]};

  // weights sum to 8, so the worst case 8*255 = 2040 fits in 11 bits
  assign sum = 11'(LUMA_R) * {3'b000, r8}
             + 11'(LUMA_G) * {3'b000, g8}
             + 11'(LUMA_B) * {3'b000, b8};

  assign y = 8'(sum >> LUMA_SHIFT);

endmodule

// File: rtl/cam_frame_capture.sv
// Camera-domain frame capture: pairs bytes into RGB565 pixels, decimates
// in both axes and writes one frame linearly into the scratchpad.
// Optional build macro CAM_GRAY_EN: write {8'h00, luma} instead of RGB565.
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int COLS       = 640,
  parameter int ROWS       = 480,
  parameter int DEC_SHIFT  = 3,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                 cam_xclk,
  input  logic                 resetn,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  cam_frame_capture_if.master  bus
);

  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);

  cap_state_e            state;
  cap_state_e            state_nx;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  phase;
  logic [7:0]            hi;
  logic                  href_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_full;

  logic                  capturing;
  logic                  href_fall;
  logic                  keep;
  logic [15:0]           pix_raw;
  logic [15:0]           pix_out;

  assign capturing = (state == ST_CAPTURE);
  assign href_fall = capturing && href_q && !bus.cam_href;
  assign pix_raw   = {hi, bus.cam_dat};

  // a pixel completes on a phase-1 byte; keep only the decimation grid
  assign keep = capturing && bus.cam_href && phase
             && (col[DEC_SHIFT-1:0] == '0) && (row[DEC_SHIFT-1:0] == '0)
             && (col < CW'(COLS)) && (row < RW'(ROWS));

`ifdef CAM_GRAY_EN
  logic [7:0] luma;

  cam_rgb2gray u_rgb2gray (
    .pix (pix_raw),
    .y   (luma)
  );

  assign pix_out = {8'h00, luma};
`else
  assign pix_out = pix_raw;
`endif

  // FSM state register
  always_ff @(posedge cam_xclk or negedge resetn) begin
    // NOTE: clocked state uses <= so every register samples pre-edge values
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  // FSM next-state and state-decoded outputs
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch)
    state_nx       = state;
    busy           = 1'b1;
    bus.cam_dat_en = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_WAIT_VS_HI;
      end
      ST_WAIT_VS_HI: begin
        if (bus.cam_vsync) state_nx = ST_WAIT_VS_LO;
      end
      ST_WAIT_VS_LO: begin
        bus.cam_dat_en = 1'b1;
        if (!bus.cam_vsync) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        bus.cam_dat_en = 1'b1;
        if (bus.cam_vsync) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // byte pairing, saturating row/col counters, address and overflow tracking
  always_ff @(posedge cam_xclk or negedge resetn) begin
    if (!resetn) begin
      col       <= '0;
      row       <= '0;
      phase     <= 1'b0;
      hi        <= '0;
      href_q    <= 1'b0;
      addr      <= '0;
      addr_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      href_q <= bus.cam_href;
      if (state == ST_IDLE && start) begin
        col       <= '0;
        row       <= '0;
        phase     <= 1'b0;
        addr      <= '0;
        addr_full <= 1'b0;
        overflow  <= 1'b0;
      end else if (capturing) begin
        if (!bus.cam_href) begin
          // a dangling phase-1 byte on an odd-length line is dropped here
          phase <= 1'b0;
          if (href_fall) begin
            col <= '0;
            if (row < RW'(ROWS)) row <= row + 1'b1;
          end
        end else begin
          phase <= ~phase;
          if (!phase) hi <= bus.cam_dat;
          else if (col < CW'(COLS)) col <= col + 1'b1;
          if (keep) begin
            // the last address is written once; later kept pixels only flag
            if (addr_full)     overflow  <= 1'b1;
            else if (&addr)    addr_full <= 1'b1;
            else               addr      <= addr + 1'b1;
          end
        end
      end else begin
        phase <= 1'b0;
      end
    end
  end

  // registered scratchpad write port and end-of-frame pulse
  always_ff @(posedge cam_xclk or negedge resetn) begin
    if (!resetn) begin
      bus.px_we   <= 1'b0;
      bus.px_addr <= '0;
      bus.px_data <= '0;
      done        <= 1'b0;
    end else begin
      bus.px_we <= keep && !addr_full;
      if (keep && !addr_full) begin
        bus.px_addr <= addr;
        bus.px_data <= pix_out;
      end
      done <= capturing && bus.cam_vsync;
    end
  end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Self-checking bench for cam_frame_capture: frames are described as byte
// lines, a reference model derives the expected writes, and a monitor
// compares every px_we strobe against the expected queue.
module tb_cam_frame_capture;

  localparam int COLS       = 8;
  localparam int ROWS       = 8;
  localparam int DEC_SHIFT  = 1;
  localparam int ADDR_WIDTH = 3;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           data;
  } wr_t;

  logic cam_xclk = 1'b0;
  logic resetn   = 1'b0;
  logic start    = 1'b0;
  logic busy;
  logic done;
  logic overflow;

  cam_frame_capture_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  cam_frame_capture #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .DEC_SHIFT  (DEC_SHIFT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .cam_xclk (cam_xclk),
    .resetn   (resetn),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bus      (bus)
  );

  always #5 cam_xclk = ~cam_xclk;

  int         checks    = 0;
  int         failures  = 0;
  int         done_cnt  = 0;
  bit         exp_ovf   = 1'b0;
  wr_t        exp_q[$];
  wr_t        mon_e;
  int         len_q[$];
  logic [7:0] dat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge cam_xclk);
    #1;
  endtask

  // expected scratchpad word for a byte pair, from the pixel format rules
  function automatic logic [15:0] ref_pixel(input logic [7:0] hb, input logic [7:0] lb);
`ifdef CAM_GRAY_EN
    int r5, g6, b5, r8, g8, b8, y;
    r5 = int'(hb) >> 3;
    g6 = ((int'(hb) & 7) << 3) | (int'(lb) >> 5);
    b5 = int'(lb) & 31;
    r8 = (r5 << 3) | (r5 >> 2);
    g8 = (g6 << 2) | (g6 >> 4);
    b8 = (b5 << 3) | (b5 >> 2);
    y  = (2 * r8 + 5 * g8 + b8) / 8;
    return 16'(y);
`else
    return {hb, lb};
`endif
  endfunction

  // reference model: walk the frame's lines, keep grid pixels inside the
  // active window, number them linearly and cap at the scratchpad size
  task automatic model_frame();
    int  n   = 0;
    int  off = 0;
    int  step = 1 << DEC_SHIFT;
    wr_t w;
    exp_ovf = 1'b0;
    foreach (len_q[r]) begin
      for (int i = 0; i < len_q[r] / 2; i++) begin
        if (r < ROWS && i < COLS && (r % step) == 0 && (i % step) == 0) begin
          if (n < (1 << ADDR_WIDTH)) begin
            w.addr = ADDR_WIDTH'(n);
            w.data = ref_pixel(dat_q[off + 2 * i], dat_q[off + 2 * i + 1]);
            exp_q.push_back(w);
          end else begin
            exp_ovf = 1'b1;
          end
          n++;
        end
      end
      off += len_q[r];
    end
  endtask

  task automatic clear_frame();
    len_q.delete();
    dat_q.delete();
  endtask

  task automatic add_line(input int len, input bit ramp);
    len_q.push_back(len);
    for (int b = 0; b < len; b++)
      dat_q.push_back(ramp ? 8'(b) : 8'($urandom));
  endtask

  task automatic build_random_frame();
    clear_frame();
    repeat ($urandom_range(1, ROWS + 2))
      add_line($urandom_range(1, 2 * COLS + 3), 1'b0);
  endtask

  task automatic drive_lines();
    int off = 0;
    foreach (len_q[r]) begin
      for (int b = 0; b < len_q[r]; b++) begin
        bus.cam_href = 1'b1;
        bus.cam_dat  = dat_q[off + b];
        tick();
      end
      off += len_q[r];
      bus.cam_href = 1'b0;
      bus.cam_dat  = 8'($urandom);
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic vsync_pulse();
    bus.cam_vsync = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    bus.cam_vsync = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
  endtask

  // one capture of the frame held in len_q/dat_q; with mid_start the
  // request arrives during a line of an already running frame
  task automatic run_frame(input bit mid_start);
    int d0;
    if (mid_start) begin
      for (int l = 0; l < 2; l++) begin
        for (int b = 0; b < 6; b++) begin
          bus.cam_href = 1'b1;
          bus.cam_dat  = 8'($urandom);
          start        = (l == 0 && b == 2);
          tick();
        end
        start        = 1'b0;
        bus.cam_href = 1'b0;
        tick();
      end
      check("busy_after_mid_start", busy, 1);
      check("dat_en_before_vsync", bus.cam_dat_en, 0);
    end else begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("dat_en_before_vsync", bus.cam_dat_en, 0);
    end
    check("overflow_cleared", overflow, 0);
    vsync_pulse();
    check("dat_en_capture", bus.cam_dat_en, 1);
    model_frame();
    drive_lines();
    d0 = done_cnt;
    bus.cam_vsync = 1'b1;
    for (int k = 0; k < 8 && done_cnt == d0; k++) tick();
    check("done_seen", done_cnt - d0, 1);
    check("pending_writes", exp_q.size(), 0);
    check("overflow_flag", overflow, exp_ovf);
    check("busy_after_done", busy, 0);
    repeat (2) tick();
    check("done_once", done_cnt - d0, 1);
    bus.cam_vsync = 1'b0;
    tick();
    exp_q.delete();
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge cam_xclk) begin
    if (done === 1'b1) done_cnt++;
    if (bus.px_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", bus.px_we, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("px_addr", bus.px_addr, mon_e.addr);
        check("px_data", bus.px_data, mon_e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.cam_dat   = 8'h00;
    bus.cam_href  = 1'b0;
    bus.cam_vsync = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_px_we", bus.px_we, 0);
    check("rst_px_addr", bus.px_addr, 0);
    check("rst_px_data", bus.px_data, 0);
    check("rst_dat_en", bus.cam_dat_en, 0);
    resetn = 1'b1;
    repeat (2) tick();

    // basic frame: four ramp lines of 16 bytes
    clear_frame();
    repeat (4) add_line(16, 1'b1);
    run_frame(1'b0);

    // odd-length lines drop their trailing byte
    clear_frame();
    add_line(5, 1'b0);
    add_line(16, 1'b0);
    add_line(5, 1'b0);
    add_line(16, 1'b0);
    run_frame(1'b0);

    // more kept pixels than scratchpad words
    clear_frame();
    repeat (ROWS) add_line(2 * COLS, 1'b0);
    run_frame(1'b0);

    // next start clears overflow (checked inside run_frame)
    build_random_frame();
    run_frame(1'b0);

    // start requested in the middle of a running frame
    build_random_frame();
    run_frame(1'b1);

    // reset in the middle of a capture (only unkept row 1 in flight)
    start = 1'b1;
    tick();
    start = 1'b0;
    vsync_pulse();
    bus.cam_href = 1'b1;
    tick();
    bus.cam_href = 1'b0;
    tick();
    bus.cam_href = 1'b1;
    repeat (3) tick();
    check("busy_before_reset", busy, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_px_we", bus.px_we, 0);
    check("mid_rst_px_addr", bus.px_addr, 0);
    check("mid_rst_px_data", bus.px_data, 0);
    check("mid_rst_dat_en", bus.cam_dat_en, 0);
    check("mid_rst_done", done, 0);
    tick();
    resetn       = 1'b1;
    bus.cam_href = 1'b0;
    d0 = done_cnt;
    bus.cam_vsync = 1'b1;
    repeat (3) tick();
    bus.cam_vsync = 1'b0;
    tick();
    check("no_done_after_reset", done_cnt - d0, 0);

    // randomized frames after reset
    repeat (8) begin
      build_random_frame();
      run_frame($urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
